wbc_round_sched: RTL and testbench
==================================

Name: wbc_round_sched

Overview:
Sequences the whitebox round-constant generator and the round datapath through a full encryption run. On a start handshake it latches the algorithm mode and the final outer-round index. It then steps outer_round from 0 upward, spending STEPS datapath-ready cycles in each outer round, and signals done at the end. Its outer_round and alg_mode outputs connect directly to the round-constant generator's inputs.

Parameters:
STEPS, 4, datapath cycles per outer round (legal range 1..2^STEP_W)
STEP_W, 3, width of the step counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a run; sampled only in IDLE
mode_in  input  3  algorithm mode: 000 spn8, 001 spn16, 010 spn32, 011 warx, 100 spn24, 101 yoroi16, 110 yoroi32
last_round  input  4  final outer_round index of the run (0..15)
dp_ready  input  1  datapath accepts the current step; when low, the scheduler stalls
outer_round  output  4  current outer round, to the round-constant generator
alg_mode  output  3  latched mode, to the round-constant generator
step  output  STEP_W  step index within the current outer round
round_start  output  1  high on step 0 of every outer round
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at the end of a run
err  output  1  one-cycle pulse when start arrives with mode_in=111

Behaviour:
- Reset (rst_n low at a clock edge) applies regardless of state, including mid-run.
  - Reset values: state IDLE; outer_round, alg_mode and step all 0; round_start, busy, done and err all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with mode_in != 111: next cycle is RUN, with alg_mode=mode_in, last_q=last_round, outer_round=0, step=0.
  - start=1 with mode_in=111: err=1 for one cycle; stay in IDLE; no other register changes.
  - start=0: hold all registers.
- RUN:
  - busy=1 (combinational on state).
  - round_start = (step==0) & RUN (combinational).
  - On an edge with dp_ready=1:
    - if step != STEPS-1: step+1.
    - else if outer_round != last_q: step=0, outer_round+1.
    - else: go to DONE, holding outer_round and step.
  - dp_ready=0: hold all registers (stall); no limit on stall length.
  - start is ignored.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next cycle: IDLE.
  - start is ignored in DONE; the earliest accepted restart is the first IDLE cycle.
- outer_round and alg_mode keep their final values in IDLE until the next accepted start.
  - This keeps the round-constant generator output stable for readback.
- Latency:
  - start accepted → first round_start: 1 cycle.
  - A run with no stalls occupies (last_round+1)*STEPS cycles in RUN, then 1 cycle in DONE.
- Boundaries:
  - last_round=0: exactly one outer round.
  - last_round=15: outer_round reaches 15 and never wraps.
  - STEPS=1: round_start stays high every RUN cycle; outer_round advances each ready cycle.
- mode_in and last_round are sampled only at start; later changes have no effect mid-run.

Optional Feature:
WBC_SCHED_DEC_EN
- Defined:
  - Adds input dir (1 bit), sampled with start.
  - dir=1 (decryption): outer_round is loaded with last_round and counts down to 0; DONE is entered after the final step of round 0.
  - dir=0: behaviour is identical to the undefined case.
- Undefined: the dir port does not exist; runs always count up.

Test Plan:
1. Reset, then start with mode_in=000, last_round=2, dp_ready=1 → round_start on cycles 1, 5, 9; outer_round 0, 1, 2; done on cycle 13; busy high on cycles 1..12.
2. Start with mode_in=111 → err pulses for 1 cycle; busy stays 0; outer_round and alg_mode are unchanged.
3. Mid-run, hold dp_ready=0 for 5 cycles → step and outer_round frozen; the run completes 5 cycles later than test 1.
4. Assert rst_n=0 during RUN at outer_round=1 → next cycle is IDLE with all outputs 0; a new start works normally.
5. last_round=0, STEPS=1, start held high continuously → RUN 1 cycle, DONE 1 cycle, IDLE 1 cycle, then restart; start is ignored in RUN and DONE.
6. With WBC_SCHED_DEC_EN defined: dir=1, last_round=3 → outer_round sequence 3, 2, 1, 0, then done.

Source files
------------

// File: rtl/wbc_round_sched.sv
// wbc_round_sched: steps the whitebox round-constant generator and round
// datapath through one encryption run. A start handshake latches the mode and
// final outer-round index. The scheduler then walks outer_round, spending
// STEPS datapath-ready cycles per outer round, and pulses done at the end.
// Optional feature macro: WBC_SCHED_DEC_EN adds a 'dir' input. With dir=1 the
// run counts outer_round down from last_round to 0 (decryption order).

module wbc_round_sched #(
    parameter int STEPS  = 4,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode_in,
    input  logic [3:0]        last_round,
    input  logic              dp_ready,
`ifdef WBC_SCHED_DEC_EN
    input  logic              dir,
`endif
    output logic [3:0]        outer_round,
    output logic [2:0]        alg_mode,
    output logic [STEP_W-1:0] step,
    output logic              round_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [2:0]        MODE_BAD  = 3'b111;

    state_t     state;
    logic [3:0] last_q;
    logic       round_final;
    logic [3:0] next_round;
    logic [3:0] first_round;

`ifdef WBC_SCHED_DEC_EN
    logic dir_q;

    // Terminal round, next round and the start round depend on run direction
    always_comb begin
        round_final = dir_q ? (outer_round == 4'd0) : (outer_round == last_q);
        next_round  = dir_q ? (outer_round - 4'd1) : (outer_round + 4'd1);
        first_round = dir ? last_round : 4'd0;
    end
`else
    // Runs always count up from round 0 to the latched final round
    always_comb begin
        round_final = (outer_round == last_q);
        next_round  = outer_round + 4'd1;
        first_round = 4'd0;
    end
`endif

    // Status flags decoded straight from the current state and step
    always_comb begin
        busy        = (state == RUN);
        round_start = (state == RUN) && (step == '0);
    end

    // Main sequencer: handshake, step/round counting, done and err pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            outer_round <= 4'd0;
            alg_mode    <= 3'd0;
            step        <= '0;
            last_q      <= 4'd0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef WBC_SCHED_DEC_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode_in == MODE_BAD) begin
                            err <= 1'b1;
                        end else begin
                            state       <= RUN;
                            alg_mode    <= mode_in;
                            last_q      <= last_round;
                            outer_round <= first_round;
                            step        <= '0;
`ifdef WBC_SCHED_DEC_EN
                            dir_q       <= dir;
`endif
                        end
                    end
                end
                RUN: begin
                    if (dp_ready) begin
                        if (step != STEP_LAST) begin
                            step <= step + STEP_W'(1);
                        end else if (!round_final) begin
                            step        <= '0;
                            outer_round <= next_round;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbc_round_sched.sv
// tb_wbc_round_sched: directed bench for wbc_round_sched. A scoreboard queue
// holds the expected (cycle, outer_round) of every round_start of a run; the
// monitor pops and compares as the DUT produces them. A second instance with
// STEPS=1 covers the single-step boundary and the held-start restart.

module tb_wbc_round_sched;

    typedef struct {
        int cyc;
        int rnd;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] mode_in;
    logic [3:0] last_round;
    logic       dp_ready;
    logic [3:0] outer_round;
    logic [2:0] alg_mode;
    logic [2:0] step;
    logic       round_start;
    logic       busy;
    logic       done;
    logic       err;
`ifdef WBC_SCHED_DEC_EN
    logic       dir;
`endif

    logic       start1;
    logic [2:0] mode1;
    logic [3:0] last1;
    logic [3:0] outer_round1;
    logic [2:0] alg_mode1;
    logic [0:0] step1;
    logic       round_start1;
    logic       busy1;
    logic       done1;
    logic       err1;

    int   n_assert;
    int   n_fail;
    exp_t sb_q[$];

    wbc_round_sched #(.STEPS(4), .STEP_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode_in     (mode_in),
        .last_round  (last_round),
        .dp_ready    (dp_ready),
`ifdef WBC_SCHED_DEC_EN
        .dir         (dir),
`endif
        .outer_round (outer_round),
        .alg_mode    (alg_mode),
        .step        (step),
        .round_start (round_start),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    wbc_round_sched #(.STEPS(1), .STEP_W(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .mode_in     (mode1),
        .last_round  (last1),
        .dp_ready    (dp_ready),
`ifdef WBC_SCHED_DEC_EN
        .dir         (1'b0),
`endif
        .outer_round (outer_round1),
        .alg_mode    (alg_mode1),
        .step        (step1),
        .round_start (round_start1),
        .busy        (busy1),
        .done        (done1),
        .err         (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] m, input logic [3:0] l, input logic d);
        start      = s;
        mode_in    = m;
        last_round = l;
        dp_ready   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRun(input int first_rnd, input int last_rnd);
        int k;
        k = 0;
        if (first_rnd <= last_rnd) begin
            for (int r = first_rnd; r <= last_rnd; r++) begin
                sb_q.push_back('{cyc: 1 + 4 * k, rnd: r});
                k++;
            end
        end else begin
            for (int r = first_rnd; r >= last_rnd; r--) begin
                sb_q.push_back('{cyc: 1 + 4 * k, rnd: r});
                k++;
            end
        end
    endtask

    // Called right after start has been driven: follows the run to done
    task automatic runMonitor(input string tag, input int stall_at, input int stall_len,
                              input int frz_step, input int frz_rnd, input int exp_mode,
                              input int exp_done, input int exp_final);
        int   cyc;
        int   bcount;
        bit   saw;
        exp_t e;
        cyc    = 0;
        bcount = 0;
        saw    = 1'b0;
        tick();
        cyc        = 1;
        start      = 1'b0;
        mode_in    = 3'b101;
        last_round = 4'd9;
        while (cyc <= 200) begin
            if (round_start === 1'b1) begin
                checkOutput({tag, "_sb_empty"}, (sb_q.size() == 0), 0);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    checkOutput({tag, "_rs_cycle"}, cyc, e.cyc);
                    checkOutput({tag, "_rs_round"}, outer_round, e.rnd);
                    checkOutput({tag, "_rs_mode"}, alg_mode, exp_mode);
                    checkOutput({tag, "_rs_step"}, step, 0);
                end
            end
            if (busy === 1'b1) bcount++;
            if (stall_len > 0 && cyc > stall_at && cyc <= stall_at + stall_len) begin
                checkOutput({tag, "_stall_step"}, step, frz_step);
                checkOutput({tag, "_stall_round"}, outer_round, frz_rnd);
            end
            if (stall_len > 0 && cyc == stall_at) dp_ready = 1'b0;
            if (stall_len > 0 && cyc == stall_at + stall_len) dp_ready = 1'b1;
            if (done === 1'b1) begin
                saw = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        checkOutput({tag, "_done_cycle"}, saw ? cyc : -1, exp_done);
        checkOutput({tag, "_busy_cycles"}, bcount, exp_done - 1);
        checkOutput({tag, "_sb_left"}, sb_q.size(), 0);
        sb_q.delete();
        dp_ready = 1'b1;
        tick();
        checkOutput({tag, "_idle_done"}, done, 0);
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_round"}, outer_round, exp_final);
        checkOutput({tag, "_idle_mode"}, alg_mode, exp_mode);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start1   = 1'b0;
        mode1    = 3'd0;
        last1    = 4'd0;
`ifdef WBC_SCHED_DEC_EN
        dir      = 1'b0;
`endif
        applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("rst_outer_round", outer_round, 0);
        checkOutput("rst_alg_mode", alg_mode, 0);
        checkOutput("rst_step", step, 0);
        checkOutput("rst_round_start", round_start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic run, last_round=2");
        pushRun(0, 2);
        applyStimulus(1'b1, 3'b000, 4'd2, 1'b1);
        runMonitor("t1", 0, 0, 0, 0, 0, 13, 2);

        $display("[TB] stalled run, 5 stall cycles");
        sb_q.push_back('{cyc: 1, rnd: 0});
        sb_q.push_back('{cyc: 5, rnd: 1});
        sb_q.push_back('{cyc: 14, rnd: 2});
        applyStimulus(1'b1, 3'b011, 4'd2, 1'b1);
        runMonitor("t3", 6, 5, 1, 1, 3, 18, 2);

        $display("[TB] illegal mode start");
        applyStimulus(1'b1, 3'b111, 4'd5, 1'b1);
        tick();
        start = 1'b0;
        checkOutput("t2_err_pulse", err, 1);
        checkOutput("t2_busy", busy, 0);
        checkOutput("t2_outer_round", outer_round, 2);
        checkOutput("t2_alg_mode", alg_mode, 3);
        tick();
        checkOutput("t2_err_clear", err, 0);
        checkOutput("t2_busy_after", busy, 0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 3'b001, 4'd5, 1'b1);
        tick();
        start = 1'b0;
        repeat (4) tick();
        checkOutput("t4_pre_round", outer_round, 1);
        checkOutput("t4_pre_rs", round_start, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t4_outer_round", outer_round, 0);
        checkOutput("t4_alg_mode", alg_mode, 0);
        checkOutput("t4_step", step, 0);
        checkOutput("t4_round_start", round_start, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_done", done, 0);
        checkOutput("t4_err", err, 0);
        tick();
        checkOutput("t4_still_idle", busy, 0);
        pushRun(0, 0);
        applyStimulus(1'b1, 3'b110, 4'd0, 1'b1);
        runMonitor("t4r", 0, 0, 0, 0, 6, 5, 0);

        $display("[TB] last_round=15 boundary");
        pushRun(0, 15);
        applyStimulus(1'b1, 3'b100, 4'd15, 1'b1);
        runMonitor("t15", 0, 0, 0, 0, 4, 65, 15);

        $display("[TB] STEPS=1 with start held high");
        start1 = 1'b1;
        mode1  = 3'b010;
        last1  = 4'd0;
        tick();
        checkOutput("t5_c1_busy", busy1, 1);
        checkOutput("t5_c1_rs", round_start1, 1);
        checkOutput("t5_c1_round", outer_round1, 0);
        checkOutput("t5_c1_mode", alg_mode1, 2);
        tick();
        checkOutput("t5_c2_done", done1, 1);
        checkOutput("t5_c2_busy", busy1, 0);
        tick();
        checkOutput("t5_c3_done", done1, 0);
        checkOutput("t5_c3_busy", busy1, 0);
        tick();
        checkOutput("t5_c4_busy", busy1, 1);
        checkOutput("t5_c4_rs", round_start1, 1);
        start1 = 1'b0;
        tick();
        checkOutput("t5_c5_done", done1, 1);
        tick();

        $display("[TB] STEPS=1 multi-round");
        start1 = 1'b1;
        last1  = 4'd3;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t5m_rs", round_start1, 1);
            checkOutput("t5m_round", outer_round1, k);
            tick();
        end
        checkOutput("t5m_done", done1, 1);
        tick();

`ifdef WBC_SCHED_DEC_EN
        $display("[TB] decrypt direction, last_round=3");
        pushRun(3, 0);
        dir = 1'b1;
        applyStimulus(1'b1, 3'b001, 4'd3, 1'b1);
        runMonitor("t6", 0, 0, 0, 0, 1, 17, 0);
        dir = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
